inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the PC register. Reads the
//  instruction at PC's address from instruction memory (req/ack), holds it in
//  the IR driven to PC and decode, and pulses enable_fetch so PC advances.
//  Re-pulses without refetching while PC counts out a branch (opcode 100110).
// PARAMETERS
//  ADDR_WIDTH  10    instruction address width (matches PC address)
//  MEM_SIZE    1024  memory depth; MEM_SIZE-1 = PC reset value, MEM_SIZE-2 = end of program
//  TIMEOUT     16    max REQ cycles without im_ack before retry
// PORTS
//  clk           in   1           clock, all state on rising edge
//  rst           in   1           asynchronous, active-low reset
//  pc_addr       in   ADDR_WIDTH  current PC address (PC updates on falling edge)
//  enable_fetch  out  1           advance pulse to PC (drives PC enable_fetch and enable_mem)
//  im_req        out  1           instruction memory read request
//  im_addr       out  ADDR_WIDTH  read address, stable while im_req=1
//  im_rdata      in   32          read data, valid when im_ack=1
//  im_ack        in   1           read complete; sampled only while im_req=1
//  ir            out  32          instruction register (to PC and decode)
//  ir_valid      out  1           ir holds a new, unconsumed instruction
//  id_ready      in   1           decode accepts ir when ir_valid=1
//  done          out  1           program end reached (sticky until reset)
//  err_timeout   out  1           sticky: at least one memory timeout occurred
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ir=0, ir_valid=0, im_req=0, im_addr=0,
//   enable_fetch=0, done=0, err_timeout=0, br_cnt=0, to_cnt=0. Reset mid-REQ abandons the read.
//  is_br = (ir[30:25]==6'b100110). All outputs registered.
//  IDLE: pc_addr==MEM_SIZE-2 -> STOP; ==MEM_SIZE-1 -> PULSE (primes PC to 0); else -> REQ.
//  REQ: im_req=1, im_addr=pc_addr captured on entry; to_cnt increments each cycle.
//   im_ack=1 -> ir<=im_rdata, ir_valid<=1, br_cnt<=0, im_req<=0, -> HOLD.
//   to_cnt==TIMEOUT-1 and no ack -> err_timeout<=1, im_req low one cycle (IDLE), re-request.
//  HOLD: ir_valid=1, ir stable; id_ready=1 -> ir_valid<=0, -> PULSE. No timeout here.
//  PULSE: enable_fetch=1 exactly one cycle (PC samples it at the mid-cycle falling edge);
//   if is_br, br_cnt<=br_cnt+1 (2-bit, saturates at 3). -> SETTLE.
//  SETTLE: enable_fetch=0; is_br && br_cnt<3 -> PULSE (no memory access, ir kept);
//   else pc_addr==MEM_SIZE-2 -> STOP; else -> REQ at the new pc_addr.
//  Branch: exactly 3 enable_fetch pulses per branch, PULSE/SETTLE alternating.
//   The REQ after the 3rd pulse is issued even if pc_addr is unchanged (branch-to-self).
//   Non-branch whose PC is unchanged (zero-offset jump): refetch the same address.
//  STOP: done=1; no im_req, no enable_fetch; ir/ir_valid frozen; left only by reset.
//  ir changes only on the im_ack cycle; held through all PULSE/SETTLE cycles, as PC reads it.
//  Latency: ack cycle -> ir_valid next cycle. Best-case throughput: 4 cycles/instruction.
//  im_ack outside REQ is ignored. No simultaneous req/enable_fetch ever.
// TESTING
//  1 Release rst, pc_addr=0x3FF: one enable_fetch pulse; PC model -> 0; im_req=1, im_addr=0.
//  2 im_ack in REQ, im_rdata=0x00000001, id_ready=0 for 5 cycles: ir=0x00000001,
//    ir_valid=1 held, no enable_fetch; id_ready=1 -> one pulse, then REQ at 1.
//  3 ir=0x4C000000 (branch), PC model taken to 0x020: 3 enable_fetch pulses 2 cycles apart,
//    no im_req between, ir unchanged; then REQ with im_addr=0x020.
//  4 Branch-to-self at 0x010: after 3rd pulse pc_addr=0x010 -> REQ at 0x010, no 4th pulse.
//  5 TIMEOUT=16, im_ack held low 16 cycles: err_timeout=1, im_req low 1 cycle, re-request at
//    same im_addr; ack then completes normally.
//  6 pc_addr=0x3FE in SETTLE: done=1, no further im_req/enable_fetch over 20 cycles;
//    separately rst=0 mid-REQ: all outputs 0 before next clk edge.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage feeding the PC register and decode.
// Fetches the word at pc_addr through a req/ack port, holds it in ir until
// decode takes it, then pulses enable_fetch so the PC advances. A branch
// instruction gets three pulses with no refetch in between, so the PC can
// count out the branch while it reads the same ir.
module inst_fetch #(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_SIZE   = 1024,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    output logic                  enable_fetch,
    output logic                  im_req,
    output logic [ADDR_WIDTH-1:0] im_addr,
    input  logic [31:0]           im_rdata,
    input  logic                  im_ack,
    output logic [31:0]           ir,
    output logic                  ir_valid,
    input  logic                  id_ready,
    output logic                  done,
    output logic                  err_timeout
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]       TO_MAX    = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_PRIME  = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_END    = ADDR_WIDTH'(MEM_SIZE - 2);
    localparam logic [5:0]            BR_OPCODE = 6'b100110;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        HOLD   = 3'd2,
        PULSE  = 3'd3,
        SETTLE = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t                state_reg, state_next;
    logic [31:0]           ir_reg, ir_next;
    logic                  ir_valid_reg, ir_valid_next;
    logic [1:0]            br_cnt_reg, br_cnt_next;
    logic [TO_W-1:0]       to_cnt_reg, to_cnt_next;
    logic                  err_reg, err_next;
    logic [ADDR_WIDTH-1:0] im_addr_reg, im_addr_next;
    logic                  enable_fetch_reg;
    logic                  im_req_reg;
    logic                  done_reg;
    logic                  is_br;

    assign is_br = (ir_reg[30:25] == BR_OPCODE);

    // Next-state and datapath decisions; strobe outputs follow the next state
    always_comb begin
        state_next    = state_reg;
        ir_next       = ir_reg;
        ir_valid_next = ir_valid_reg;
        br_cnt_next   = br_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        err_next      = err_reg;
        im_addr_next  = im_addr_reg;

        case (state_reg)
            IDLE: begin
                if (pc_addr == PC_END) begin
                    state_next = STOP;
                end else if (pc_addr == PC_PRIME) begin
                    // PC still at its reset value: one pulse wraps it to 0
                    state_next = PULSE;
                end else begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (im_ack) begin
                    ir_next       = im_rdata;
                    ir_valid_next = 1'b1;
                    br_cnt_next   = 2'd0;
                    state_next    = HOLD;
                end else if (to_cnt_reg == TO_MAX) begin
                    // Drop the request for one cycle, then retry via IDLE
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (id_ready) begin
                    ir_valid_next = 1'b0;
                    state_next    = PULSE;
                end
            end
            PULSE: begin
                if (is_br && (br_cnt_reg != 2'd3)) begin
                    br_cnt_next = br_cnt_reg + 2'd1;
                end
                state_next = SETTLE;
            end
            SETTLE: begin
                // pc_addr has moved on the falling edge of the PULSE cycle
                if (is_br && (br_cnt_reg < 2'd3)) begin
                    state_next = PULSE;
                end else if (pc_addr == PC_END) begin
                    state_next = STOP;
                end else begin
                    state_next = REQ;
                end
            end
            STOP: begin
                state_next = STOP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Every fresh entry into REQ latches the address and restarts the timer
        if ((state_next == REQ) && (state_reg != REQ)) begin
            im_addr_next = pc_addr;
            to_cnt_next  = '0;
        end
    end

    // State and output registers; async active-low clear abandons any read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            ir_reg           <= '0;
            ir_valid_reg     <= 1'b0;
            br_cnt_reg       <= 2'd0;
            to_cnt_reg       <= '0;
            err_reg          <= 1'b0;
            im_addr_reg      <= '0;
            enable_fetch_reg <= 1'b0;
            im_req_reg       <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ir_reg           <= ir_next;
            ir_valid_reg     <= ir_valid_next;
            br_cnt_reg       <= br_cnt_next;
            to_cnt_reg       <= to_cnt_next;
            err_reg          <= err_next;
            im_addr_reg      <= im_addr_next;
            enable_fetch_reg <= (state_next == PULSE);
            im_req_reg       <= (state_next == REQ);
            done_reg         <= (state_next == STOP);
        end
    end

    assign enable_fetch = enable_fetch_reg;
    assign im_req       = im_req_reg;
    assign im_addr      = im_addr_reg;
    assign ir           = ir_reg;
    assign ir_valid     = ir_valid_reg;
    assign done         = done_reg;
    assign err_timeout  = err_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch. A small PC model advances on each
// enable_fetch (falling edge); a transaction-level reference predicts the
// next fetch address and the number of pulses for every instruction.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [9:0]  pc_addr;
    logic        enable_fetch;
    logic        im_req;
    logic [9:0]  im_addr;
    logic [31:0] im_rdata;
    logic        im_ack;
    logic [31:0] ir;
    logic        ir_valid;
    logic        id_ready;
    logic        done;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap = 0;

    // PC environment state
    logic [31:0] cur_inst;
    logic [9:0]  br_target;
    int          pulse_n;

    inst_fetch #(.ADDR_WIDTH(10), .MEM_SIZE(1024), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .pc_addr(pc_addr),
        .enable_fetch(enable_fetch),
        .im_req(im_req),
        .im_addr(im_addr),
        .im_rdata(im_rdata),
        .im_ack(im_ack),
        .ir(ir),
        .ir_valid(ir_valid),
        .id_ready(id_ready),
        .done(done),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_branch(input logic [31:0] d);
        return d[30:25] == 6'b100110;
    endfunction

    function automatic logic [31:0] rand_inst(input bit want_br);
        logic [31:0] d;
        d = $urandom;
        if (want_br) d[30:25] = 6'b100110;
        else if (is_branch(d)) d[25] = ~d[25];
        return d;
    endfunction

    // PC model: plain increment, or a branch counted out over three pulses
    task automatic pc_step();
        if (rst && enable_fetch) begin
            if (is_branch(cur_inst)) begin
                pulse_n++;
                if (pulse_n == 3) pc_addr = br_target;
            end else begin
                pc_addr = pc_addr + 10'd1;
            end
        end
    endtask

    // One clock: PC reacts at the falling edge, outputs sampled 1 after rising edge
    task automatic tick();
        @(negedge clk);
        pc_step();
        @(posedge clk);
        #1;
        if (im_req && enable_fetch) overlap++;
    endtask

    // Full instruction: starts with im_req sampled high, ends at the next REQ
    task automatic run_instr(input logic [31:0] data, input logic [9:0] target,
                             input int ack_dly, input int rdy_dly, input bit noise,
                             input string tag, output int cycles);
        logic [9:0] cur, exp_next;
        int  exp_pulses, pulses, last_pulse;
        bit  stable_ok, got_req, bad_gap;
        cur        = pc_addr;
        exp_pulses = is_branch(data) ? 3 : 1;
        exp_next   = is_branch(data) ? target : cur + 10'd1;
        cycles     = 0;
        stable_ok  = 1'b1;

        n_tests++;
        if (im_req !== 1'b1 || im_addr !== cur) begin
            n_fail++;
            $display("FAIL %s req: im_req=%0b im_addr=%h, expected 1/%h", tag, im_req, im_addr, cur);
        end

        for (int i = 0; i < ack_dly; i++) begin
            im_rdata = $urandom;
            tick(); cycles++;
            if (im_req !== 1'b1 || im_addr !== cur || ir_valid !== 1'b0 || enable_fetch !== 1'b0)
                stable_ok = 1'b0;
        end
        im_rdata  = data;
        im_ack    = 1'b1;
        cur_inst  = data;
        br_target = target;
        pulse_n   = 0;
        tick(); cycles++;
        im_ack   = 1'b0;
        im_rdata = $urandom;

        n_tests++;
        if (ir !== data || ir_valid !== 1'b1 || im_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s capture: ir=%h valid=%0b req=%0b, expected %h/1/0", tag, ir, ir_valid, im_req, data);
        end

        for (int i = 0; i < rdy_dly; i++) begin
            if (noise) begin im_ack = 1'($urandom_range(0, 1)); im_rdata = $urandom; end
            tick(); cycles++;
            if (ir !== data || ir_valid !== 1'b1 || enable_fetch !== 1'b0 || im_req !== 1'b0)
                stable_ok = 1'b0;
        end
        im_ack   = 1'b0;
        id_ready = 1'b1;
        tick(); cycles++;
        id_ready = 1'b0;

        pulses = 0; got_req = 1'b0; last_pulse = -2; bad_gap = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (ir !== data || ir_valid !== 1'b0) stable_ok = 1'b0;
            if (enable_fetch === 1'b1) begin
                if (pulses > 0 && cyc - last_pulse != 2) bad_gap = 1'b1;
                last_pulse = cyc;
                pulses++;
            end
            if (im_req === 1'b1) begin got_req = 1'b1; break; end
            if (noise) begin im_ack = 1'($urandom_range(0, 1)); im_rdata = $urandom; end
            tick(); cycles++;
        end
        im_ack = 1'b0;

        n_tests++;
        if (pulses != exp_pulses || bad_gap) begin
            n_fail++;
            $display("FAIL %s pulses: got %0d (gap_err=%0b), expected %0d spaced 2", tag, pulses, bad_gap, exp_pulses);
        end
        n_tests++;
        if (!got_req || im_addr !== exp_next || pc_addr !== exp_next) begin
            n_fail++;
            $display("FAIL %s next_req: req=%0b im_addr=%h pc=%h, expected 1/%h", tag, got_req, im_addr, pc_addr, exp_next);
        end
        n_tests++;
        if (!stable_ok) begin
            n_fail++;
            $display("FAIL %s stability: ir/ir_valid/strobes disturbed, expected ir=%h held", tag, data);
        end
        $display("[TB] %s addr=%h inst=%h pulses=%0d next=%h cycles=%0d", tag, cur, data, pulses, im_addr, cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_addr = 10'h3FF; im_rdata = '0; im_ack = 1'b0; id_ready = 1'b0;
        cur_inst = '0; br_target = '0; pulse_n = 0;
        #2 rst = 1'b0;
        tick(); tick();
        n_tests++;
        if (ir !== 32'h0 || ir_valid !== 1'b0 || im_req !== 1'b0 || im_addr !== 10'h0 ||
            enable_fetch !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ir=%h v=%0b req=%0b addr=%h ef=%0b done=%0b err=%0b, expected all 0",
                     ir, ir_valid, im_req, im_addr, enable_fetch, done, err_timeout);
        end
        $display("[TB] reset held, outputs ir=%h req=%0b ef=%0b", ir, im_req, enable_fetch);
    endtask

    task automatic test_prime();
        rst = 1'b1;
        tick();
        n_tests++;
        if (enable_fetch !== 1'b1 || im_req !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_pulse: ef=%0b req=%0b, expected 1/0", enable_fetch, im_req);
        end
        tick(); tick();
        n_tests++;
        if (pc_addr !== 10'h000 || im_req !== 1'b1 || im_addr !== 10'h000 || enable_fetch !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_req: pc=%h req=%0b addr=%h ef=%0b, expected 000/1/000/0", pc_addr, im_req, im_addr, enable_fetch);
        end
        $display("[TB] prime pc=%h im_addr=%h", pc_addr, im_addr);
    endtask

    task automatic test_hold();
        int c;
        run_instr(32'h0000_0001, 10'h000, 0, 5, 1'b0, "hold", c);
    endtask

    task automatic test_branch();
        int c;
        run_instr(32'h4C00_0000, 10'h020, 2, 1, 1'b0, "branch", c);
        run_instr(rand_inst(1'b1), 10'h010, 1, 0, 1'b0, "branch_to_010", c);
        run_instr(rand_inst(1'b1), 10'h010, 0, 2, 1'b0, "branch_self", c);
    endtask

    task automatic test_timeout();
        bit ok;
        int c;
        ok = 1'b1;
        im_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (im_req !== 1'b1 || err_timeout !== 1'b0 || im_addr !== 10'h010) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout_wait: request dropped or err early, expected 16 req cycles at 010");
        end
        tick();
        n_tests++;
        if (im_req !== 1'b0 || err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_drop: req=%0b err=%0b, expected 0/1", im_req, err_timeout);
        end
        tick();
        n_tests++;
        if (im_req !== 1'b1 || im_addr !== 10'h010) begin
            n_fail++;
            $display("FAIL timeout_retry: req=%0b addr=%h, expected 1/010", im_req, im_addr);
        end
        $display("[TB] timeout err=%0b retry addr=%h", err_timeout, im_addr);
        run_instr(rand_inst(1'b0), 10'h000, 3, 1, 1'b0, "after_timeout", c);
        n_tests++;
        if (err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%0b, expected 1", err_timeout);
        end
    endtask

    task automatic test_random();
        int c;
        for (int n = 0; n < 30; n++) begin
            run_instr(rand_inst($urandom_range(0, 2) == 0), 10'($urandom_range(0, 767)),
                      $urandom_range(0, 5), $urandom_range(0, 3), 1'b1, "random", c);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        for (int n = 0; n < 3; n++) begin
            run_instr(rand_inst(1'b0), 10'h000, 0, 0, 1'b0, "b2b", c);
            n_tests++;
            if (c != 4) begin
                n_fail++;
                $display("FAIL b2b_rate: got %0d cycles, expected 4", c);
            end
        end
        run_instr(rand_inst(1'b1), 10'($urandom_range(0, 767)), 0, 0, 1'b0, "b2b_branch", c);
        n_tests++;
        if (c != 8) begin
            n_fail++;
            $display("FAIL b2b_branch_rate: got %0d cycles, expected 8", c);
        end
    endtask

    task automatic test_stop();
        logic [31:0] d;
        int pulses, reqs;
        d = rand_inst(1'b1);
        im_rdata = d; im_ack = 1'b1;
        cur_inst = d; br_target = 10'h3FE; pulse_n = 0;
        tick();
        im_ack = 1'b0;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        pulses = 0; reqs = 0;
        for (int i = 0; i < 26; i++) begin
            if (enable_fetch === 1'b1) pulses++;
            if (im_req === 1'b1) reqs++;
            im_ack = 1'($urandom_range(0, 1));
            tick();
        end
        im_ack = 1'b0;
        n_tests++;
        if (pulses != 3 || reqs != 0) begin
            n_fail++;
            $display("FAIL stop_quiet: pulses=%0d reqs=%0d, expected 3/0", pulses, reqs);
        end
        n_tests++;
        if (done !== 1'b1 || ir !== d || ir_valid !== 1'b0 || pc_addr !== 10'h3FE) begin
            n_fail++;
            $display("FAIL stop_state: done=%0b ir=%h v=%0b pc=%h, expected 1/%h/0/3fe", done, ir, ir_valid, pc_addr, d);
        end
        $display("[TB] stop done=%0b pulses=%0d reqs=%0d", done, pulses, reqs);
    endtask

    task automatic test_reset_mid_req();
        int c;
        rst = 1'b0;
        tick(); tick();
        pc_addr = 10'h3FF; cur_inst = '0; pulse_n = 0;
        rst = 1'b1;
        tick(); tick(); tick();
        run_instr(rand_inst(1'b0), 10'h000, 1, 1, 1'b0, "pre_reset", c);
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (ir !== 32'h0 || ir_valid !== 1'b0 || im_req !== 1'b0 || im_addr !== 10'h0 ||
            enable_fetch !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_req: ir=%h v=%0b req=%0b addr=%h ef=%0b done=%0b err=%0b, expected all 0",
                     ir, ir_valid, im_req, im_addr, enable_fetch, done, err_timeout);
        end
        $display("[TB] async reset mid-REQ req=%0b ir=%h", im_req, ir);
    endtask

    task automatic test_no_overlap();
        n_tests++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL no_overlap: %0d cycles with im_req and enable_fetch both high, expected 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_hold();
        test_branch();
        test_timeout();
        test_random();
        test_back_to_back();
        test_stop();
        test_reset_mid_req();
        test_no_overlap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
